// File: rtl/muu_request_join.sv
`default_nettype none
// ============================================================================
//  Module   : muu_request_join
//  Purpose  : Joins a request metadata word with its single key word into one
//             command. The command is registered, and the request's value
//             beats are then forwarded with length checking. If a value
//             stream is too long, it is cut short and the remaining beats are
//             drained.
//  Options  : MUU_REQJOIN_NOPFILTER_EN -- when defined, drop NOP requests
//             (opcode 8'hFF with vallen 0) without producing a command.
//  Revision : 1.0  initial release
// ============================================================================
module muu_request_join #(
   parameter int NET_META_WIDTH = 64,
   parameter int OPS_META_WIDTH = 96,
   parameter int USER_BITS      = 3,
   parameter int VALUE_WIDTH    = 512
) (
   input  logic                                                   clk,
   input  logic                                                   rst,
   input  logic [NET_META_WIDTH+OPS_META_WIDTH+USER_BITS-1:0]     meta_data,
   input  logic                                                   meta_valid,
   output logic                                                   meta_ready,
   input  logic [63:0]                                            key_data,
   input  logic                                                   key_last,
   input  logic                                                   key_valid,
   output logic                                                   key_ready,
   input  logic [VALUE_WIDTH-1:0]                                 val_in_data,
   input  logic                                                   val_in_last,
   input  logic                                                   val_in_valid,
   output logic                                                   val_in_ready,
   output logic [64+NET_META_WIDTH+OPS_META_WIDTH+USER_BITS-1:0]  cmd_data,
   output logic                                                   cmd_valid,
   input  logic                                                   cmd_ready,
   output logic [VALUE_WIDTH-1:0]                                 val_out_data,
   output logic                                                   val_out_last,
   output logic                                                   val_out_valid,
   input  logic                                                   val_out_ready,
   output logic [15:0]                                            err_count,
   output logic [31:0]                                            req_count
);

   localparam int META_W         = NET_META_WIDTH + OPS_META_WIDTH + USER_BITS;
   localparam int CMD_W          = 64 + META_W;
   localparam int WORDS_PER_BEAT = VALUE_WIDTH / 64;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CMD   = 2'd1;
   localparam logic [1:0] ST_VALUE = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CMD_W-1:0] r_cmd_data;
   logic [16:0]      r_beats_left;
   logic [15:0]      r_err_count;
   logic [31:0]      r_req_count;

   logic [15:0]      w_vallen;
   logic [16:0]      w_beats_calc;
   logic             w_drop;
   logic             w_pop;
   logic             w_cmd_xfer;
   logic             w_val_xfer;
   logic             w_drain_end;
   logic             w_last_beat;
   logic             w_early_last;
   logic             w_overrun;
   logic             w_err_inc;

   // Value length is counted in 64-bit words; round up to whole beats.
   assign w_vallen     = meta_data[79:64];
   assign w_beats_calc = ({1'b0, w_vallen} + 17'(WORDS_PER_BEAT - 1)) / 17'(WORDS_PER_BEAT);

`ifdef MUU_REQJOIN_NOPFILTER_EN
   logic [7:0] w_opcode;
   assign w_opcode = meta_data[151:144];
   assign w_drop   = (w_opcode == 8'hFF) && (w_vallen == 16'd0);
`else
   assign w_drop   = 1'b0;
`endif

   assign w_pop        = (r_state == ST_IDLE) && meta_valid && key_valid;
   assign w_cmd_xfer   = (r_state == ST_CMD) && cmd_ready;
   assign w_val_xfer   = (r_state == ST_VALUE) && val_in_valid && val_out_ready;
   assign w_drain_end  = (r_state == ST_DRAIN) && val_in_valid && val_in_last;
   assign w_last_beat  = (r_beats_left == 17'd1);
   assign w_early_last = w_val_xfer && val_in_last && (r_beats_left > 17'd1);
   assign w_overrun    = w_val_xfer && !val_in_last && w_last_beat;
   assign w_err_inc    = (w_pop && !key_last) || w_early_last || w_overrun;

   assign cmd_data     = r_cmd_data;
   assign cmd_valid    = !rst && (r_state == ST_CMD);
   assign val_out_data = val_in_data;
   assign err_count    = r_err_count;
   assign req_count    = r_req_count;

   // Handshake outputs; both input streams are offered ready together so they pop as a pair.
   always_comb begin
      meta_ready    = 1'b0;
      key_ready     = 1'b0;
      val_in_ready  = 1'b0;
      val_out_valid = 1'b0;
      val_out_last  = 1'b0;
      if (!rst) begin
         case (r_state)
            ST_IDLE: begin
               meta_ready = meta_valid && key_valid;
               key_ready  = meta_valid && key_valid;
            end
            ST_VALUE: begin
               val_out_valid = val_in_valid;
               val_in_ready  = val_out_ready;
               val_out_last  = val_in_last || w_last_beat;
            end
            ST_DRAIN: begin
               val_in_ready = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state selection.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pop && !w_drop) begin
               w_state_nxt = ST_CMD;
            end
         end
         ST_CMD: begin
            if (w_cmd_xfer) begin
               w_state_nxt = (r_beats_left != 17'd0) ? ST_VALUE : ST_IDLE;
            end
         end
         ST_VALUE: begin
            if (w_val_xfer) begin
               if (w_last_beat) begin
                  w_state_nxt = val_in_last ? ST_IDLE : ST_DRAIN;
               end else if (val_in_last) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DRAIN: begin
            if (w_drain_end) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command capture and remaining-beat tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cmd_data   <= '0;
         r_beats_left <= '0;
      end else if (w_pop && !w_drop) begin
         r_cmd_data   <= {key_data, meta_data};
         r_beats_left <= w_beats_calc;
      end else if (w_val_xfer) begin
         r_beats_left <= r_beats_left - 17'd1;
      end
   end

   // Statistics: errors saturate, accepted commands wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count <= '0;
         r_req_count <= '0;
      end else begin
         if (w_err_inc && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
         end
         if (w_cmd_xfer) begin
            r_req_count <= r_req_count + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/muu_request_join.md
MUU_REQUEST_JOIN -- requirements
Module: muu_request_join

Interface
REQ-001 SHALL have parameter NET_META_WIDTH, default 64, network metadata width.
REQ-002 SHALL have parameter OPS_META_WIDTH, default 96, operation metadata width.
REQ-003 SHALL have parameter USER_BITS, default 3, user-id width.
REQ-004 SHALL have parameter VALUE_WIDTH, default 512, value beat width, a multiple of 64.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 meta_data  in  NET_META_WIDTH+OPS_META_WIDTH+USER_BITS  request meta: [63:0] net_meta, [79:64] vallen (64-bit words), [87:80] keylen, [95:88] peerid, [151:144] opcode, top USER_BITS userid.
REQ-008 meta_valid/meta_ready  in/out  1/1  meta handshake.
REQ-009 key_data/key_last/key_valid  in  64/1/1  key word stream; exactly one word per request.
REQ-010 key_ready  out  1  key handshake.
REQ-011 val_in_data/val_in_last/val_in_valid  in  VALUE_WIDTH/1/1  packed value beats.
REQ-012 val_in_ready  out  1  value-input handshake.
REQ-013 cmd_data  out  64+NET_META_WIDTH+OPS_META_WIDTH+USER_BITS  joined command: {key word, meta word}; cmd_valid out 1; cmd_ready in 1.
REQ-014 val_out_data/val_out_last/val_out_valid  out  VALUE_WIDTH/1/1  value beats; val_out_ready in 1.
REQ-015 err_count  out  16  saturating count of value-framing errors.
REQ-016 req_count  out  32  wrapping count of commands accepted downstream.

Function
REQ-017 SHALL implement states ST_IDLE, ST_CMD, ST_VALUE, ST_DRAIN.
REQ-018 In ST_IDLE, meta_ready and key_ready SHALL both be 1 only when meta_valid and key_valid are both 1, so both streams pop in the same cycle; neither pops alone.
REQ-019 On that pop, the block SHALL register cmd_data, load beats_left = ceil(vallen*64/VALUE_WIDTH), and enter ST_CMD; cmd_valid SHALL rise the next cycle (latency 1).
REQ-020 In ST_CMD, cmd_valid SHALL hold 1 with stable cmd_data until cmd_ready=1; on transfer, req_count SHALL increment, then the next state is ST_VALUE if beats_left>0, else ST_IDLE.
REQ-021 In ST_VALUE, the value path SHALL be combinational pass-through: val_out_valid=val_in_valid, val_in_ready=val_out_ready, data and last unmodified; beats_left SHALL decrement per transfer.
REQ-022 Value transfer with val_in_last=1 and beats_left>1 (early last) SHALL increment err_count and go to ST_IDLE.
REQ-023 Value transfer with beats_left==1 and val_in_last=0 SHALL force val_out_last=1 on that beat, increment err_count, and go to ST_DRAIN.
REQ-024 Value transfer with beats_left==1 and val_in_last=1 SHALL go to ST_IDLE with no error.
REQ-025 ST_DRAIN SHALL hold val_in_ready=1 and val_out_valid=0, discard beats up to and including the one with val_in_last=1, then go to ST_IDLE.
REQ-026 Outside ST_VALUE, val_out_valid SHALL be 0 and val_in_ready SHALL be 0, except in ST_DRAIN.
REQ-027 err_count SHALL saturate at 16'hFFFF; req_count SHALL wrap at 2^32.
REQ-028 key_last is informational; key_last=0 on a popped key word SHALL increment err_count and is otherwise ignored.

Reset
REQ-029 On rst, the block SHALL enter ST_IDLE and drive cmd_valid=0, val_out_valid=0, meta_ready=0, key_ready=0, val_in_ready=0, err_count=0, req_count=0, cmd_data=0.
REQ-030 rst mid-operation SHALL abandon the current request; beats still pending upstream are not drained.

Configuration
REQ-031 With macro MUU_REQJOIN_NOPFILTER_EN defined, a request with opcode 8'hFF and vallen 0 SHALL be popped and discarded in ST_IDLE: no cmd_valid, no req_count increment, stays in ST_IDLE.
REQ-032 With MUU_REQJOIN_NOPFILTER_EN undefined, opcode 8'hFF SHALL be forwarded like any other opcode.

Verification
REQ-033 meta (vallen=0, opcode=1) plus key 64'hA5 with cmd_ready=1 -> cmd_valid 1 cycle after pop, cmd_data[63+...] key=64'hA5, req_count=1, no value beats.
REQ-034 vallen=16, two value beats with last on the second, val_out_ready toggling 1/0 -> both beats emerge in order, last on beat 2, err_count=0.
REQ-035 vallen=16, last on beat 1 -> err_count=1, state returns to ST_IDLE, next request is processed normally.
REQ-036 vallen=8, three beats with last on beat 3 -> one beat out with forced last, beats 2-3 dropped, err_count=1.
REQ-037 meta_valid=1 with key_valid=0 for 10 cycles -> meta_ready stays 0; key arrives -> both pop in the same cycle.
REQ-038 rst asserted during ST_VALUE -> all outputs at reset values next cycle, counters 0; with MUU_REQJOIN_NOPFILTER_EN, opcode FF/vallen 0 -> no cmd_valid.
